// File: rtl/gpio_cfg_pkg.sv
// Shared definitions for the GPIO serial configuration loader.
//
// Contents:
//   loader_state_e  : control FSM states (IDLE, FETCH, SHIFT, LOAD)
//   CFG_BITS_DEF    : default width of one per-pad configuration word
//   *_BIT constants : bit positions of the fields inside a configuration word
package gpio_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2,
    LOAD  = 2'd3
  } loader_state_e;

  localparam int CFG_BITS_DEF = 13;

  // Field layout of one pad configuration word.
  localparam int MGMT_EN_BIT  = 0;
  localparam int OUT_DIS_BIT  = 1;
  localparam int HOLD_OVR_BIT = 2;
  localparam int INP_DIS_BIT  = 3;
  localparam int MOD_SEL_BIT  = 4;
  localparam int AN_EN_BIT    = 5;
  localparam int AN_SEL_BIT   = 6;
  localparam int AN_POL_BIT   = 7;
  localparam int SLOW_BIT     = 8;
  localparam int VTRIP_BIT    = 9;
  localparam int DM_LSB       = 10;
  localparam int DM_MSB       = 12;

endpackage

// File: rtl/serial_bit_timer.sv
// Serial bit timer for the GPIO configuration chain.
//
// Divides the core clock into serial_clock half-periods of CLK_DIV cycles.
// While run is high, div_cnt counts 0..CLK_DIV-1; at the last count of a
// half-period the phase flag flips (only when toggle_en is high). With
// toggle_en low the counter still runs, so the caller can time a plain
// CLK_DIV-cycle interval (used for the load strobe) with serial_clock held low.
//
// Ports:
//   clock        : core clock
//   resetn       : asynchronous active-low reset
//   run          : count enable; low clears counter and phase
//   toggle_en    : allow the phase flag to flip at half-period end
//   rise_tick    : last cycle of a low half-period (serial_clock rises next)
//   bit_end      : last cycle of a high half-period (one bit finished)
//   serial_clock : registered chain shift clock (the phase flag)
module serial_bit_timer #(
  parameter int CLK_DIV = 2
) (
  input  logic clock,
  input  logic resetn,
  input  logic run,
  input  logic toggle_en,
  output logic rise_tick,
  output logic bit_end,
  output logic serial_clock
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [7:0] div_cnt_reg;
  logic       phase_reg;
  logic       half_end;

  assign half_end     = run && (div_cnt_reg == DIV_LAST);
  assign rise_tick    = half_end && !phase_reg;
  assign bit_end      = half_end && phase_reg;
  assign serial_clock = phase_reg;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      div_cnt_reg <= '0;
      phase_reg   <= 1'b0;
    end else if (!run) begin
      div_cnt_reg <= '0;
      phase_reg   <= 1'b0;
    end else if (half_end) begin
      div_cnt_reg <= '0;
      if (toggle_en) begin
        phase_reg <= ~phase_reg;
      end
    end else begin
      div_cnt_reg <= div_cnt_reg + 8'd1;
    end
  end

endmodule

// File: rtl/gpio_serial_loader.sv
// GPIO serial configuration loader.
//
// On start, fetches one CFG_BITS word per pad from the register file
// (highest pad index first), shifts each word MSB-first into the pad control
// chain, then pulses serial_load for CLK_DIV cycles so all pads latch together.
//
// Ports:
//   clock, resetn   : core clock, asynchronous active-low reset
//   start           : single-cycle request, honoured only in IDLE
//   abort           : terminate the transfer without a load pulse
//   busy            : high while a transfer is in progress
//   done            : one-cycle pulse after a completed load
//   cfg_addr        : index of the pad word being fetched
//   cfg_data        : register-file read data for cfg_addr
//   serial_clock    : chain shift clock (registered)
//   serial_load     : chain latch strobe (registered)
//   serial_data_out : chain data input (registered)
module gpio_serial_loader
  import gpio_cfg_pkg::*;
#(
  parameter int NPADS    = 38,
  parameter int CFG_BITS = CFG_BITS_DEF,
  parameter int CLK_DIV  = 2
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     start,
  input  logic                     abort,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(NPADS)-1:0] cfg_addr,
  input  logic [CFG_BITS-1:0]      cfg_data,
  output logic                     serial_clock,
  output logic                     serial_load,
  output logic                     serial_data_out
);

  localparam int AW = $clog2(NPADS);
  localparam int BW = $clog2(CFG_BITS);
  localparam logic [AW-1:0] ADDR_LAST = AW'(NPADS - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(CFG_BITS - 1);

  loader_state_e state_reg, state_next;

  logic [CFG_BITS-1:0] shreg_reg;
  logic [BW-1:0]       bit_cnt_reg;
  logic [AW-1:0]       addr_reg;
  logic                sdo_reg;
  logic                busy_reg, done_reg, load_reg;
  logic                busy_next, done_next, load_next;

  logic timer_run, timer_toggle, rise_tick, bit_end;
  logic last_bit, word_done;

  // The timer also runs in LOAD (without toggling) to time the strobe width.
  // Abort stops it immediately so serial_clock is low the following cycle.
  assign timer_run    = ((state_reg == SHIFT) || (state_reg == LOAD)) && !abort;
  assign timer_toggle = (state_reg == SHIFT);

  serial_bit_timer #(
    .CLK_DIV(CLK_DIV)
  ) u_bit_timer (
    .clock       (clock),
    .resetn      (resetn),
    .run         (timer_run),
    .toggle_en   (timer_toggle),
    .rise_tick   (rise_tick),
    .bit_end     (bit_end),
    .serial_clock(serial_clock)
  );

  assign last_bit  = (bit_cnt_reg == '0);
  assign word_done = (state_reg == SHIFT) && bit_end && last_bit;

  // State register plus registered status outputs.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg <= IDLE;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      load_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      load_reg  <= load_next;
    end
  end

  // Next-state logic. Abort dominates everything, including start in IDLE.
  always_comb begin
    state_next = state_reg;
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (start) state_next = FETCH;
        FETCH:   state_next = SHIFT;
        SHIFT:   if (word_done) state_next = (addr_reg == '0) ? LOAD : FETCH;
        LOAD:    if (rise_tick) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Output logic: next values of the registered status outputs.
  always_comb begin
    busy_next = (state_next != IDLE);
    load_next = (state_next == LOAD);
    done_next = (state_reg == LOAD) && (state_next == IDLE) && !abort;
  end

  // Datapath: shift register, bit counter, pad address, serial data.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      shreg_reg   <= '0;
      bit_cnt_reg <= BIT_LAST;
      addr_reg    <= ADDR_LAST;
      sdo_reg     <= 1'b0;
    end else if (abort) begin
      // Chain keeps whatever was shifted; only our pointers rewind.
      bit_cnt_reg <= BIT_LAST;
      addr_reg    <= ADDR_LAST;
      sdo_reg     <= 1'b0;
    end else begin
      case (state_reg)
        FETCH: begin
          shreg_reg   <= cfg_data;
          bit_cnt_reg <= BIT_LAST;
          sdo_reg     <= cfg_data[CFG_BITS-1];
        end
        SHIFT: begin
          if (bit_end) begin
            if (!last_bit) begin
              // Data moves on the same edge serial_clock falls.
              bit_cnt_reg <= bit_cnt_reg - 1'b1;
              shreg_reg   <= shreg_reg << 1;
              sdo_reg     <= shreg_reg[CFG_BITS-2];
            end else if (addr_reg != '0) begin
              addr_reg <= addr_reg - 1'b1;
            end else begin
              sdo_reg <= 1'b0;
            end
          end
        end
        LOAD: begin
          if (rise_tick) begin
            addr_reg <= ADDR_LAST;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy            = busy_reg;
  assign done            = done_reg;
  assign cfg_addr        = addr_reg;
  assign serial_load     = load_reg;
  assign serial_data_out = sdo_reg;

endmodule

// File: tb/tb_gpio_serial_loader.sv
// Testbench for gpio_serial_loader. Three instances share one clock:
//   A: NPADS=2,  CLK_DIV=1   B: NPADS=2, CLK_DIV=3   C: NPADS=38, CLK_DIV=2
// Only the selected instance sees start/abort; its outputs are observed
// against a model of the daisy-chained pad registers.
module tb_gpio_serial_loader;

  localparam int CFG = 13;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn, start, abort;
  int   sel;
  logic [CFG-1:0] words [0:37];

  logic busy_a, done_a, sclk_a, load_a, sdo_a;
  logic [0:0] addr_a;
  logic [CFG-1:0] data_a;
  logic busy_b, done_b, sclk_b, load_b, sdo_b;
  logic [0:0] addr_b;
  logic [CFG-1:0] data_b;
  logic busy_c, done_c, sclk_c, load_c, sdo_c;
  logic [5:0] addr_c;
  logic [CFG-1:0] data_c;

  assign data_a = words[addr_a];
  assign data_b = words[addr_b];
  assign data_c = words[addr_c];

  gpio_serial_loader #(.NPADS(2), .CFG_BITS(CFG), .CLK_DIV(1)) dut_a (
    .clock(clk), .resetn(resetn), .start(start && sel == 0), .abort(abort && sel == 0),
    .busy(busy_a), .done(done_a), .cfg_addr(addr_a), .cfg_data(data_a),
    .serial_clock(sclk_a), .serial_load(load_a), .serial_data_out(sdo_a));

  gpio_serial_loader #(.NPADS(2), .CFG_BITS(CFG), .CLK_DIV(3)) dut_b (
    .clock(clk), .resetn(resetn), .start(start && sel == 1), .abort(abort && sel == 1),
    .busy(busy_b), .done(done_b), .cfg_addr(addr_b), .cfg_data(data_b),
    .serial_clock(sclk_b), .serial_load(load_b), .serial_data_out(sdo_b));

  gpio_serial_loader #(.NPADS(38), .CFG_BITS(CFG), .CLK_DIV(2)) dut_c (
    .clock(clk), .resetn(resetn), .start(start && sel == 2), .abort(abort && sel == 2),
    .busy(busy_c), .done(done_c), .cfg_addr(addr_c), .cfg_data(data_c),
    .serial_clock(sclk_c), .serial_load(load_c), .serial_data_out(sdo_c));

  logic o_busy, o_done, o_sclk, o_load, o_sdo;
  logic [5:0] o_addr;

  always_comb begin
    o_busy = 1'b0; o_done = 1'b0; o_sclk = 1'b0; o_load = 1'b0; o_sdo = 1'b0; o_addr = '0;
    case (sel)
      0: begin o_busy = busy_a; o_done = done_a; o_sclk = sclk_a; o_load = load_a; o_sdo = sdo_a; o_addr = 6'(addr_a); end
      1: begin o_busy = busy_b; o_done = done_b; o_sclk = sclk_b; o_load = load_b; o_sdo = sdo_b; o_addr = 6'(addr_b); end
      default: begin o_busy = busy_c; o_done = done_c; o_sclk = sclk_c; o_load = load_c; o_sdo = sdo_c; o_addr = addr_c; end
    endcase
  end

  typedef struct {
    int sel; int npads; int div; bit rnd;
    logic [CFG-1:0] w1; logic [CFG-1:0] w0;
    int restart_at; int exp_busy; int exp_rises; int exp_loads;
  } vec_t;

  vec_t vecs [7];

  int n_vec = 0;
  int n_bad = 0;

  // Observation state (touched only by the test process).
  int cyc, rises, busy_cnt, done_cnt, done_ok, load_cnt, sdo_viol;
  int high_bad, low_ok, low_gap, low_bad, run_len;
  int npads_cur, div_cur;
  bit seen_high;
  logic p_sclk, p_sdo, p_busy, p_load;
  logic stream [$];
  logic [CFG-1:0] chain [0:37];
  logic [CFG-1:0] latched [0:37];

  function automatic void check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endfunction

  task automatic clear_mon();
    cyc = 0; rises = 0; busy_cnt = 0; done_cnt = 0; done_ok = 0; load_cnt = 0;
    sdo_viol = 0; high_bad = 0; low_ok = 0; low_gap = 0; low_bad = 0; run_len = 0;
    seen_high = 1'b0;
    stream.delete();
    for (int i = 0; i < 38; i++) begin
      chain[i]   = '0;
      latched[i] = ~words[i];
    end
    p_sclk = o_sclk; p_sdo = o_sdo; p_busy = o_busy; p_load = o_load;
  endtask

  // One core cycle, sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (o_sclk && !p_sclk) begin
      rises++;
      stream.push_back(o_sdo);
      for (int i = npads_cur - 1; i > 0; i--) chain[i] = {chain[i][CFG-2:0], chain[i-1][CFG-1]};
      chain[0] = {chain[0][CFG-2:0], o_sdo};
    end
    if (o_sclk && (o_sdo !== p_sdo)) sdo_viol++;
    if (o_sclk == p_sclk) begin
      run_len++;
    end else begin
      if (p_sclk) begin
        if (run_len != div_cur) high_bad++;
        seen_high = 1'b1;
      end else if (seen_high) begin
        if (run_len == div_cur) low_ok++;
        else if (run_len == div_cur + 1) low_gap++;  // FETCH cycle between words
        else low_bad++;
      end
      run_len = 1;
    end
    if (o_busy) busy_cnt++;
    if (o_done) begin
      done_cnt++;
      if (!o_busy && p_busy) done_ok++;
    end
    if (o_load) begin
      load_cnt++;
      if (!p_load) for (int i = 0; i < npads_cur; i++) latched[i] = chain[i];
    end
    p_sclk = o_sclk; p_sdo = o_sdo; p_busy = o_busy; p_load = o_load;
  endtask

  task automatic select(input int s, input int np, input int dv);
    sel = s; npads_cur = np; div_cur = dv;
    @(negedge clk);
    clear_mon();
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int errs, k;
    if (v.rnd) begin
      for (int i = 0; i < 38; i++) words[i] = CFG'($urandom);
    end else begin
      words[0] = v.w0;
      words[1] = v.w1;
    end
    select(v.sel, v.npads, v.div);
    start = 1'b1; tick(); start = 1'b0;
    while (done_cnt == 0 && cyc < 4000) begin
      if (cyc == v.restart_at) start = 1'b1;
      tick();
      start = 1'b0;
    end
    check($sformatf("v%0d timeout", idx), (cyc >= 4000) ? 1 : 0, 0);
    tick(); tick();
    check($sformatf("v%0d busy_cycles", idx), busy_cnt, v.exp_busy);
    check($sformatf("v%0d rises", idx), rises, v.exp_rises);
    check($sformatf("v%0d load_cycles", idx), load_cnt, v.exp_loads);
    check($sformatf("v%0d done_count", idx), done_cnt, 1);
    check($sformatf("v%0d done_after_busy", idx), done_ok, 1);
    check($sformatf("v%0d sdo_change_while_high", idx), sdo_viol, 0);
    check($sformatf("v%0d high_len_bad", idx), high_bad, 0);
    check($sformatf("v%0d low_len_bad", idx), low_bad, 0);
    check($sformatf("v%0d low_len_ok", idx), low_ok, v.npads * (CFG - 1));
    check($sformatf("v%0d fetch_gaps", idx), low_gap, v.npads - 1);
    check($sformatf("v%0d addr_after", idx), int'(o_addr), v.npads - 1);
    errs = 0; k = 0;
    for (int p = v.npads - 1; p >= 0; p--) begin
      for (int b = CFG - 1; b >= 0; b--) begin
        if (k < stream.size() && stream[k] !== words[p][b]) errs++;
        k++;
      end
    end
    check($sformatf("v%0d stream_len", idx), stream.size(), v.npads * CFG);
    check($sformatf("v%0d stream_bit_errs", idx), errs, 0);
    for (int p = 0; p < v.npads; p++)
      check($sformatf("v%0d pad%0d latched", idx, p), int'(latched[p]), int'(words[p]));
    $display("vec %0d: sel=%0d div=%0d busy=%0d rises=%0d loads=%0d dones=%0d",
             idx, v.sel, v.div, busy_cnt, rises, load_cnt, done_cnt);
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; abort = 1'b0; sel = 0; npads_cur = 2; div_cur = 1;
    for (int i = 0; i < 38; i++) words[i] = '0;

    //            sel np div rnd  w1        w0        rst busy  rises loads
    vecs[0] = '{0, 2,  1, 1'b0, 13'h1A5C, 13'h0403, -1,  55,  26,  1};
    vecs[1] = '{0, 2,  1, 1'b0, 13'h1FFF, 13'h0000, 10,  55,  26,  1};
    vecs[2] = '{0, 2,  1, 1'b0, 13'h0001, 13'h1000, -1,  55,  26,  1};
    vecs[3] = '{1, 2,  3, 1'b0, 13'h0AAA, 13'h1555, -1, 161,  26,  3};
    vecs[4] = '{1, 2,  3, 1'b0, 13'h1234, 13'h0F0F, 10, 161,  26,  3};
    vecs[5] = '{2, 38, 2, 1'b1, 13'h0000, 13'h0000, -1, 2016, 494, 2};
    vecs[6] = '{2, 38, 2, 1'b1, 13'h0000, 13'h0000, 10, 2016, 494, 2};

    // Reset values.
    repeat (3) @(negedge clk);
    check("reset busy", int'(o_busy), 0);
    check("reset done", int'(o_done), 0);
    check("reset sclk", int'(o_sclk), 0);
    check("reset load", int'(o_load), 0);
    check("reset sdo", int'(o_sdo), 0);
    check("reset addr A", int'(o_addr), 1);
    sel = 2; #1;
    check("reset addr C", int'(o_addr), 37);
    @(negedge clk);
    resetn = 1'b1;
    $display("reset values checked");

    // Asynchronous reset in the middle of SHIFT.
    words[0] = 13'h1FFF; words[1] = 13'h1FFF;
    select(0, 2, 1);
    start = 1'b1; tick(); start = 1'b0;
    while (!(o_sclk && o_sdo && rises >= 3) && cyc < 100) tick();
    check("rst_mid reached shift", int'(o_sclk), 1);
    resetn = 1'b0; #1;
    check("rst_mid busy", int'(o_busy), 0);
    check("rst_mid sclk", int'(o_sclk), 0);
    check("rst_mid sdo", int'(o_sdo), 0);
    check("rst_mid load", int'(o_load), 0);
    check("rst_mid done", int'(o_done), 0);
    check("rst_mid addr", int'(o_addr), 1);
    repeat (3) tick();
    resetn = 1'b1;
    repeat (60) tick();
    check("rst_mid no load", load_cnt, 0);
    check("rst_mid no done", done_cnt, 0);
    check("rst_mid stays idle", int'(o_busy), 0);
    $display("reset mid-shift: rises=%0d loads=%0d", rises, load_cnt);

    // Start and abort together in IDLE: abort wins.
    select(0, 2, 1);
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    repeat (4) tick();
    check("start+abort busy_cycles", busy_cnt, 0);
    $display("start+abort idle: busy=%0d", busy_cnt);

    // Abort after 5 bits.
    words[0] = 13'h1FFF; words[1] = 13'h1FFF;
    select(0, 2, 1);
    start = 1'b1; tick(); start = 1'b0;
    while (!(rises == 5 && !o_sclk) && cyc < 100) tick();
    check("abort reached bit5", rises, 5);
    check("abort sdo before", int'(o_sdo), 1);
    abort = 1'b1; tick(); abort = 1'b0;
    check("abort busy", int'(o_busy), 0);
    check("abort sclk", int'(o_sclk), 0);
    check("abort sdo", int'(o_sdo), 0);
    check("abort load", int'(o_load), 0);
    check("abort done", int'(o_done), 0);
    repeat (60) tick();
    check("abort no load", load_cnt, 0);
    check("abort no done", done_cnt, 0);
    check("abort addr", int'(o_addr), 1);
    $display("abort after 5 bits: rises=%0d loads=%0d dones=%0d", rises, load_cnt, done_cnt);
    run_vec(vecs[0], 99);

    // Table-driven transfers.
    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
